// File: rtl/serial_subtractor.sv
// Bit-serial subtractor/adder. Processes one bit per clock, LSB first, through a single
// full-subtractor/full-adder cell and a borrow/carry flop. Accepts parallel operands on
// start, returns a parallel result WIDTH cycles later with a one-cycle done pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             sub_q, sub_d;
  logic             bout_q, bout_d;

  // Single bit cell; borrow and carry differ only in the polarity of the minuend bit.
  logic bit_a, bit_b, bit_d, bit_c;
  assign bit_a = xs_q[0];
  assign bit_b = ys_q[0];
  assign bit_d = bit_a ^ bit_b ^ c_q;
  assign bit_c = sub_q ? ((~bit_a & bit_b) | (~(bit_a ^ bit_b) & c_q))
                       : ((bit_a & bit_b) | ((bit_a ^ bit_b) & c_q));

  // Next-state: accept in Idle/Done, shift one bit per cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          xs_d    = x_i;
          ys_d    = y_i;
          c_d     = bin_i;
          sub_d   = sub_i;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        xs_d  = xs_q >> 1;
        ys_d  = ys_q >> 1;
        acc_d = {bit_d, acc_q[WIDTH-1:1]};
        c_d   = bit_c;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          diff_d  = {bit_d, acc_q[WIDTH-1:1]};
          bout_d  = bit_c;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      bout_q  <= bout_d;
    end
  end

  assign busy_o = (state_q == StShift);
  assign done_o = (state_q == StDone);
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor/adder, LSB-first, one bit per clock. It uses a single full-subtractor/full-adder cell and a borrow/carry flop. It takes parallel operands with a start/busy/done handshake and returns a parallel result. It is the inverse-direction companion to the combinational full adder: a small-area arithmetic unit for datapaths that trade latency for gate count.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk; accepted only when not busy.
- sub  input  1  mode, latched at accept: 1 = x − y − bin, 0 = x + y + bin.
- x  input  WIDTH  minuend / addend; latched at accept.
- y  input  WIDTH  subtrahend / addend; latched at accept.
- bin  input  1  borrow-in (sub) / carry-in (add); latched at accept.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when diff/bout are updated.
- diff  output  WIDTH  result; registered; held until the next completion.
- bout  output  1  borrow-out (sub) / carry-out (add); registered; held with diff.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- Accept: start=1 in IDLE or DONE.
  - Load x and y into shift registers and bin into the borrow/carry flop c.
  - Latch sub, clear the bit counter to 0, go to SHIFT.
- SHIFT processes one bit per cycle on a = xs[0], b = ys[0].
  - Sub: d = a^b^c; c' = (~a&b) | (~(a^b)&c).
  - Add: d = a^b^c; c' = (a&b) | ((a^b)&c).
  - Shift xs and ys right by 1. Shift d into the MSB of the internal accumulator acc (right shift). Increment the counter.
- Completion: on the cycle processing bit WIDTH−1:
  - diff ← final acc, including this bit.
  - bout ← c'.
  - Go to DONE.
- DONE lasts one cycle with done=1, then returns to IDLE, unless start=1, which is accepted as above.
- start while in SHIFT is ignored: no queueing, no effect on the operation in flight.
- x, y, bin and sub may change freely after the accept edge.
- Results are modulo 2^WIDTH.
  - Sub: bout=1 iff x < y + bin (unsigned).
  - Add: bout=1 iff x + y + bin ≥ 2^WIDTH.
- Reset (rst_n=0, any time, including mid-SHIFT), applied asynchronously:
  - State → IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Shift registers, acc, c and counter cleared.
  - The operation in flight is discarded. The first edge after release with start=1 is a normal accept.

## Timing
- Reset values: busy=0, done=0, diff={WIDTH{1'b0}}, bout=0.
- Accept at rising edge N, then:
  - busy=1 from edge N to edge N+WIDTH (exactly WIDTH cycles).
  - diff/bout update at edge N+WIDTH.
  - done=1 from edge N+WIDTH to edge N+WIDTH+1.
- Latency from accept edge to result is WIDTH cycles.
- Back-to-back: start held high in DONE gives an accept at edge N+WIDTH+1, so throughput is one result per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- diff/bout change only at a completion edge or at reset.

## Test plan
- Reset: assert rst_n=0 mid-cycle with no clock → busy=0, done=0, diff=8'h00, bout=0 immediately. After release with start=0 for 20 cycles, all outputs stay 0.
- Basic sub (WIDTH=8): x=8'h5A, y=8'h23, bin=0, sub=1, start pulse at edge N.
  - busy high for 8 cycles.
  - At edge N+8: diff=8'h37, bout=0.
  - done high exactly one cycle.
- Underflow / borrow chain:
  - x=8'h10, y=8'h20, bin=0 → diff=8'hF0, bout=1.
  - x=8'h00, y=8'h00, bin=1 → diff=8'hFF, bout=1.
- Add mode: x=8'hFF, y=8'h01, bin=0, sub=0 → diff=8'h00, bout=1. Then x=8'h12, y=8'h34, bin=1 → diff=8'h47, bout=0.
- Handshake:
  - start pulsed again 3 cycles into SHIFT with different operands → ignored; first result unchanged and on time.
  - start held high through DONE → second accept at edge N+9, second done at edge N+17.
  - Operands changed the cycle after accept → result reflects the latched values.
- Reset mid-operation: rst_n=0 after 4 bits of 8'hA5−8'h5A.
  - Outputs go to 0 at once and no done pulse occurs.
  - After release, a new start with 8'hA5−8'h5A gives diff=8'h4B, bout=0 at the normal latency.
